// File: rtl/jump_ctrl.sv
// ---------------------------------------------------------------------------
// jump_ctrl
//
// Sequences a conditional jump instruction. When a jump is decoded (start),
// the branch condition is evaluated from the compare-unit flags of that same
// cycle. A taken jump fetches two operand bytes from program ROM (high byte
// first) and then pulses pc_load with the assembled target. A jump that is
// not taken pulses skip so the PC steps over the two operand bytes.
//
// Parameters
//   ADDR_W     program-counter width, 9..16
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle strobe, jump instruction decoded (accepted in IDLE)
//   cond       condition select, sampled with start
//   zflag, oflag, cflag, sflag
//              zero / overflow / carry / sign flags, sampled with start
//   rom_data   operand byte from program ROM
//   rom_valid  rom_data valid this cycle
//   rom_req    request next operand byte (high in both fetch states)
//   pc_load    one-cycle pulse: load pc_target into PC
//   pc_target  jump destination, holds its value between jumps
//   skip       one-cycle pulse: PC advances past the operand bytes
//   busy       high whenever the controller is not idle
//   done       one-cycle pulse: instruction retired, taken or not
// ---------------------------------------------------------------------------
module jump_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cond,
    input  logic              zflag,
    input  logic              oflag,
    input  logic              cflag,
    input  logic              sflag,
    input  logic [7:0]        rom_data,
    input  logic              rom_valid,
    output logic              rom_req,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              skip,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        COMMIT   = 3'd3,
        SKIP     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-9:0]   r_hi;
    logic                r_rom_req;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_pc_target;
    logic                r_skip;
    logic                r_busy;
    logic                r_done;
    logic                w_taken;
    logic                w_lt;

    // Signed "less than" after a compare is sign xor overflow.
    assign w_lt = sflag ^ oflag;

    always_comb begin
        w_taken = 1'b0;
        case (cond)
            4'd0:    w_taken = 1'b1;
            4'd1:    w_taken = zflag;
            4'd2:    w_taken = !zflag;
            4'd3:    w_taken = cflag;
            4'd4:    w_taken = !cflag;
            4'd5:    w_taken = sflag;
            4'd6:    w_taken = !sflag;
            4'd7:    w_taken = oflag;
            4'd8:    w_taken = !oflag;
            4'd9:    w_taken = w_lt;
            4'd10:   w_taken = !w_lt;
            4'd11:   w_taken = !zflag && !w_lt;
            4'd12:   w_taken = zflag || w_lt;
            4'd13:   w_taken = !cflag && !zflag;
            4'd14:   w_taken = cflag || zflag;
            default: w_taken = 1'b0;
        endcase
    end

    // The branch decision is captured by the state chosen out of IDLE, so
    // flag changes after the start cycle have no effect. All outputs are
    // registered and change together with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hi        <= '0;
            r_rom_req   <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_skip      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            r_skip    <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_taken) begin
                            r_state   <= FETCH_HI;
                            r_rom_req <= 1'b1;
                        end else begin
                            r_state <= SKIP;
                            r_skip  <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FETCH_HI: begin
                    if (rom_valid) begin
                        // Bits of the first byte above the PC width are dropped.
                        r_hi    <= rom_data[ADDR_W-9:0];
                        r_state <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (rom_valid) begin
                        r_pc_target <= {r_hi, rom_data};
                        r_state     <= COMMIT;
                        r_rom_req   <= 1'b0;
                        r_pc_load   <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                COMMIT, SKIP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_rom_req <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req   = r_rom_req;
    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign skip      = r_skip;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, program-counter width; legal range 9..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle strobe: jump instruction decoded; operand bytes follow in ROM.
REQ-005 cond  input  4  condition select, sampled with start.
REQ-006 zflag, oflag, cflag, sflag  input  1 each  zero/overflow/carry/sign flags from compare unit, sampled with start.
REQ-007 rom_data  input  8  operand byte from program ROM.
REQ-008 rom_valid  input  1  rom_data valid this cycle.
REQ-009 rom_req  output  1  request next operand byte.
REQ-010 pc_load  output  1  one-cycle pulse: load pc_target into PC.
REQ-011 pc_target  output  ADDR_W  jump destination.
REQ-012 skip  output  1  one-cycle pulse: PC advances 2 (operand bytes skipped).
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse: instruction retired (taken or not).

Function
REQ-015 FSM states SHALL be IDLE, FETCH_HI, FETCH_LO, COMMIT, SKIP; all outputs registered.
REQ-016 In IDLE with start=1, condition SHALL be evaluated from flags/cond of that cycle and latched; later flag changes ignored.
REQ-017 Condition table: 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O; 9 S^O (signed lt); 10 !(S^O) (signed ge); 11 !Z&!(S^O) (signed gt); 12 Z|(S^O) (signed le); 13 !C&!Z (unsigned gt); 14 C|Z (unsigned le); 15 never.
REQ-018 Taken: IDLE -> FETCH_HI next cycle; not taken: IDLE -> SKIP.
REQ-019 FETCH_HI: rom_req=1; on rom_valid=1 latch rom_data[ADDR_W-9:0] as target high bits, -> FETCH_LO.
REQ-020 FETCH_LO: rom_req=1; on rom_valid=1 latch rom_data as target[7:0], -> COMMIT.
REQ-021 rom_valid=0 in a FETCH state SHALL hold state and rom_req indefinitely; rom_valid outside FETCH states ignored.
REQ-022 COMMIT: pc_load=1, done=1, pc_target=assembled address for exactly one cycle, -> IDLE.
REQ-023 SKIP: skip=1, done=1 for one cycle, -> IDLE.
REQ-024 Latency with rom_valid tied high: start at cycle T -> pc_load/done at T+3 (taken), skip/done at T+1 (not taken).
REQ-025 start while busy=1 SHALL be ignored; start in the cycle of return to IDLE is not accepted (accepted only when state is IDLE).
REQ-026 pc_load and skip SHALL never be high together; done high iff either is high.
REQ-027 pc_target SHALL hold its last value outside COMMIT; high bits above ADDR_W-9 of the first byte discarded.

Reset
REQ-028 On reset, state=IDLE; rom_req, pc_load, skip, busy, done=0; pc_target=0; latched condition=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately; no pc_load/skip/done pulse after deassertion.

Verification
REQ-030 cond=0, start, rom_valid=1, bytes 0x12,0x34 -> pc_load=1 and pc_target=0x1234 at T+3, done=1, busy low at T+4.
REQ-031 cond=1, zflag=0, start -> skip=1, done=1 at T+1; rom_req never asserted; pc_target unchanged.
REQ-032 cond=9, sflag=1, oflag=0, flags flipped the cycle after start, rom_valid delayed 3 cycles per byte -> rom_req held through stalls, pc_load at T+9 with correct target.
REQ-033 start pulsed again during FETCH_LO -> ignored; exactly one done pulse.
REQ-034 reset asserted in FETCH_LO -> all outputs 0 same cycle; no pc_load afterward; next start behaves normally.
REQ-035 Sweep cond 0..15 over all 16 flag combinations -> taken/skip matches REQ-017 table in every case.
